// File: rtl/imem_loader.sv
// imem_loader
//   Writer side of the datapath instruction memory. Receives a program as a
//   byte stream (valid/ready), expects a 16-bit big-endian word count header,
//   then assembles big-endian 32-bit instruction words and writes them to
//   consecutive instruction memory addresses starting at 0. The CPU is held
//   stopped (cpu_run=0) until the whole program has been written.
//
//   Ports
//     clk          system clock, all logic on rising edge
//     rst_n        synchronous reset, active-low
//     start        single-cycle pulse that begins a load (IDLE/DONE/ERR only)
//     in_data      program byte
//     in_valid     in_data is valid
//     in_ready     loader accepts a byte this cycle
//     im_we        instruction memory write enable, one cycle per word
//     im_addr      instruction memory write address
//     im_wdata     instruction word to write
//     cpu_run      program loaded, datapath may execute
//     words_loaded count of words written in the current load
//     err          illegal length header (0 or larger than DEPTH)
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   IDLE   | after reset, waiting for start
//   LEN_HI | waiting for length header high byte
//   LEN_LO | waiting for length header low byte, length checked here
//   DATA   | assembling and writing instruction words
//   DONE   | program loaded, cpu_run high, waiting for a reload start
//   ERR    | bad length header, err high, waiting for start
module imem_loader #(
    parameter int ADDR_W = 9,
    parameter int DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_run,
    output logic [ADDR_W:0]   words_loaded,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_HI = 3'd1,
        S_LEN_LO = 3'd2,
        S_DATA   = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    localparam logic [15:0] DEPTH_W = 16'(DEPTH);

    state_t              state_q;
    logic [7:0]          len_hi_q;
    logic [ADDR_W:0]     len_q;
    logic [1:0]          byte_cnt_q;
    logic [23:0]         asm_q;
    logic                in_ready_q;
    logic                im_we_q;
    logic [ADDR_W-1:0]   im_addr_q;
    logic [31:0]         im_wdata_q;
    logic                cpu_run_q;
    logic [ADDR_W:0]     words_loaded_q;
    logic                err_q;

    logic                accept;
    logic [15:0]         len_d;
    logic                len_bad_d;
    logic [31:0]         word_d;
    logic [ADDR_W:0]     words_loaded_d;

    always_comb begin
        accept         = in_valid && in_ready_q;
        len_d          = {len_hi_q, in_data};
        len_bad_d      = (len_d == 16'd0) || (len_d > DEPTH_W);
        word_d         = {asm_q, in_data};
        words_loaded_d = words_loaded_q + (ADDR_W+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            len_hi_q       <= '0;
            len_q          <= '0;
            byte_cnt_q     <= '0;
            asm_q          <= '0;
            in_ready_q     <= 1'b0;
            im_we_q        <= 1'b0;
            im_addr_q      <= '0;
            im_wdata_q     <= '0;
            cpu_run_q      <= 1'b0;
            words_loaded_q <= '0;
            err_q          <= 1'b0;
        end else begin
            im_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    // DONE raises cpu_run one cycle after the final write pulse
                    if (state_q == S_DONE) begin
                        cpu_run_q <= 1'b1;
                    end
                    if (start) begin
                        state_q        <= S_LEN_HI;
                        in_ready_q     <= 1'b1;
                        err_q          <= 1'b0;
                        cpu_run_q      <= 1'b0;
                        words_loaded_q <= '0;
                    end
                end
                S_LEN_HI: begin
                    if (accept) begin
                        len_hi_q <= in_data;
                        state_q  <= S_LEN_LO;
                    end
                end
                S_LEN_LO: begin
                    if (accept) begin
                        if (len_bad_d) begin
                            state_q    <= S_ERR;
                            in_ready_q <= 1'b0;
                            err_q      <= 1'b1;
                        end else begin
                            state_q        <= S_DATA;
                            len_q          <= len_d[ADDR_W:0];
                            byte_cnt_q     <= '0;
                            asm_q          <= '0;
                            words_loaded_q <= '0;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        asm_q      <= word_d[23:0];
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            im_we_q        <= 1'b1;
                            // words written so far doubles as the word address
                            im_addr_q      <= words_loaded_q[ADDR_W-1:0];
                            im_wdata_q     <= word_d;
                            words_loaded_q <= words_loaded_d;
                            if (words_loaded_d == len_q) begin
                                state_q    <= S_DONE;
                                in_ready_q <= 1'b0;
                            end
                        end
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_q;
    assign im_we        = im_we_q;
    assign im_addr      = im_addr_q;
    assign im_wdata     = im_wdata_q;
    assign cpu_run      = cpu_run_q;
    assign words_loaded = words_loaded_q;
    assign err          = err_q;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int ADDR_W = 9;
    localparam int DEPTH  = 512;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_run;
    logic [ADDR_W:0]   words_loaded;
    logic              err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;
    wr_t exp_q[$];

    imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .im_we        (im_we),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .cpu_run      (cpu_run),
        .words_loaded (words_loaded),
        .err          (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // write monitor: every im_we pulse must match the oldest expected write
    always @(negedge clk) begin
        if (rst_n && im_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr %h data %h, expected no write", im_addr, im_wdata);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(im_addr), 32'(e.addr));
                check("write_data", im_wdata, e.data);
            end
        end
    end

    task automatic expect_write(input int a, input logic [31:0] d);
        wr_t e;
        e.addr = ADDR_W'(a);
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready 0, expected 1 for byte %h", b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [7:0] basic [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                               8'hAC, 8'h09, 8'h00, 8'h04};

    task automatic basic_load(input int gap, input string tag);
        pulse_start();
        check({tag, "_ready_after_start"}, 32'(in_ready), 32'd1);
        expect_write(0, 32'h20080005);
        expect_write(1, 32'hAC090004);
        for (int i = 0; i < 10; i++) send_byte(basic[i], (i == 9) ? 0 : gap);
        @(negedge clk);
        check({tag, "_we_after_last"}, 32'(im_we), 32'd1);
        check({tag, "_run_during_we"}, 32'(cpu_run), 32'd0);
        @(negedge clk);
        check({tag, "_cpu_run"}, 32'(cpu_run), 32'd1);
        check({tag, "_words"}, 32'(words_loaded), 32'd2);
        check({tag, "_ready_done"}, 32'(in_ready), 32'd0);
        check({tag, "_addr_hold"}, 32'(im_addr), 32'd1);
        check({tag, "_data_hold"}, im_wdata, 32'hAC090004);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_im_we", 32'(im_we), 32'd0);
        check("rst_im_addr", 32'(im_addr), 32'd0);
        check("rst_im_wdata", im_wdata, 32'd0);
        check("rst_cpu_run", 32'(cpu_run), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // basic back-to-back load
        basic_load(0, "basic");

        // reload from DONE
        pulse_start();
        check("reload_run_cleared", 32'(cpu_run), 32'd0);
        check("reload_words_cleared", 32'(words_loaded), 32'd0);
        expect_write(0, 32'h12345678);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'h12, 0);
        send_byte(8'h34, 0);
        send_byte(8'h56, 0);
        send_byte(8'h78, 0);
        repeat (2) @(negedge clk);
        check("reload_cpu_run", 32'(cpu_run), 32'd1);
        check("reload_words", 32'(words_loaded), 32'd1);
        check("reload_queue_empty", 32'(exp_q.size()), 32'd0);

        // bubbles of 3 idle cycles between bytes
        basic_load(3, "bubble");

        // bad length: zero
        pulse_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        @(negedge clk);
        check("len0_err", 32'(err), 32'd1);
        check("len0_ready", 32'(in_ready), 32'd0);
        check("len0_run", 32'(cpu_run), 32'd0);

        // bad length: DEPTH+1
        pulse_start();
        check("err_cleared_by_start", 32'(err), 32'd0);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        @(negedge clk);
        check("len513_err", 32'(err), 32'd1);
        check("len513_ready", 32'(in_ready), 32'd0);

        // recovery: valid one-word load
        pulse_start();
        check("recover_err_cleared", 32'(err), 32'd0);
        expect_write(0, 32'hDEADBEEF);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hDE, 0);
        send_byte(8'hAD, 0);
        send_byte(8'hBE, 0);
        send_byte(8'hEF, 0);
        repeat (2) @(negedge clk);
        check("recover_err", 32'(err), 32'd0);
        check("recover_run", 32'(cpu_run), 32'd1);
        check("recover_words", 32'(words_loaded), 32'd1);
        check("recover_queue_empty", 32'(exp_q.size()), 32'd0);

        // full depth: word n = n
        pulse_start();
        send_byte(8'h02, 0);
        send_byte(8'h00, 0);
        for (int n = 0; n < DEPTH; n++) begin
            logic [31:0] w;
            w = 32'(n);
            expect_write(n, w);
            send_byte(w[31:24], 0);
            send_byte(w[23:16], 0);
            send_byte(w[15:8], 0);
            send_byte(w[7:0], 0);
        end
        repeat (2) @(negedge clk);
        check("full_words", 32'(words_loaded), 32'd512);
        check("full_run", 32'(cpu_run), 32'd1);
        check("full_last_addr", 32'(im_addr), 32'd511);
        check("full_last_data", im_wdata, 32'h000001FF);
        check("full_queue_empty", 32'(exp_q.size()), 32'd0);

        // reset mid-load after 6 bytes
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(basic[i], 0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_im_we", 32'(im_we), 32'd0);
        check("midrst_im_addr", 32'(im_addr), 32'd0);
        check("midrst_im_wdata", im_wdata, 32'd0);
        check("midrst_cpu_run", 32'(cpu_run), 32'd0);
        check("midrst_words", 32'(words_loaded), 32'd0);
        check("midrst_err", 32'(err), 32'd0);
        rst_n = 1'b1;

        // in_valid in IDLE is not accepted
        in_valid = 1'b1;
        in_data  = 8'h55;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd0);
        check("idle_words", 32'(words_loaded), 32'd0);
        // start together with in_valid: that byte must not be taken as header
        in_data = 8'hFF;
        start   = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b0;
        expect_write(0, 32'hCAFEF00D);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hCA, 0);
        send_byte(8'hFE, 0);
        send_byte(8'hF0, 0);
        send_byte(8'h0D, 0);
        repeat (2) @(negedge clk);
        check("after_rst_err", 32'(err), 32'd0);
        check("after_rst_run", 32'(cpu_run), 32'd1);
        check("after_rst_words", 32'(words_loaded), 32'd1);
        check("after_rst_queue_empty", 32'(exp_q.size()), 32'd0);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the datapath's instruction memory. The datapath only reads instructions (9-bit instruction index, 32-bit instruction word).
- This block receives a program as a byte stream with a valid/ready handshake and assembles big-endian 32-bit words.
- It writes those words into instruction memory at consecutive addresses. It holds the CPU stopped (cpu_run=0) until the whole program is in memory.

Parameters:
- ADDR_W, 9, instruction memory address width; matches the datapath instruction index.
- DEPTH, 512, number of instruction words the memory holds; maximum legal program length.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous reset, active-low.
- start  input  1  single-cycle pulse that begins a load.
- in_data  input  8  program byte.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  loader accepts a byte this cycle.
- im_we  output  1  instruction memory write enable (one cycle per word).
- im_addr  output  ADDR_W  instruction memory write address.
- im_wdata  output  32  instruction word to write.
- cpu_run  output  1  program loaded; datapath may execute.
- words_loaded  output  ADDR_W+1  count of words written in current load.
- err  output  1  illegal length header.

Behaviour:
- Reset (rst_n=0 at a clock edge): state=IDLE. All outputs are 0: in_ready, im_we, im_addr, im_wdata, cpu_run, words_loaded, err. The byte counter and assembly register are cleared. Reset has priority over every other input, including mid-load. A load interrupted by reset is abandoned and partial writes are not undone.
- Byte transfer: a byte is accepted only on a clock edge where in_valid=1 and in_ready=1.
- in_ready is 1 in LEN_HI, LEN_LO and DATA; it is 0 in IDLE, DONE and ERR. in_ready is registered and follows the state.
- States:
  - IDLE: start=1 -> LEN_HI. Clears err, cpu_run and words_loaded on the same edge.
  - LEN_HI: accepted byte -> len[15:8]; go to LEN_LO.
  - LEN_LO: accepted byte -> len[7:0]. If the full len is 0 or >DEPTH -> ERR, else -> DATA with the word address counter at 0.
  - DATA: accepts bytes. The first byte of each word goes to [31:24], then [23:16], [15:8], [7:0].
    - On the edge accepting the 4th byte, the next cycle has im_we=1, im_addr=word index, im_wdata=assembled word. words_loaded increments on that same edge.
    - If that word is word len-1, the state goes to DONE on the same edge.
  - DONE: in_ready=0. cpu_run=1 from the cycle after the final im_we pulse and stays high. start=1 -> LEN_HI, with cpu_run, words_loaded and err cleared on that edge.
  - ERR: err=1 and in_ready=0. start=1 -> LEN_HI and clears err. Reset also clears it.
- start outside IDLE/DONE/ERR is ignored.
- start and in_valid in the same IDLE/DONE/ERR cycle: no byte is accepted, because in_ready=0 that cycle.
- im_we is 1 for exactly one cycle per word and never twice for one address within one load. im_addr and im_wdata hold their last value while im_we=0.
- Gaps in in_valid (any length) stall assembly with no loss or duplication of bytes.
- Address wrap cannot occur, because len ≤ DEPTH is enforced. With DEPTH=512 the last address is 511.
- Max throughput is 1 byte/cycle. A word is written 1 cycle after its 4th byte.
- words_loaded is ADDR_W+1 bits wide so it can represent DEPTH.

Test Plan:
- Basic load: reset, start, then bytes 00 02 20 08 00 05 AC 09 00 04 back-to-back.
  -> im_we at addr 0 data 0x20080005, then addr 1 data 0xAC090004.
  -> cpu_run=1 one cycle after the second im_we; words_loaded=2; in_ready=0 afterwards.
- Bubbles: same stream as Basic load, with in_valid=0 for 3 cycles between every byte.
  -> identical writes and final state.
  -> no im_we during bubbles except the cycle after each 4th byte.
- Bad length: header 00 00 -> err=1, in_ready=0, no im_we. Header 02 01 with DEPTH=512 -> err=1. Then start plus a valid 1-word load -> err=0, write succeeds.
- Full depth: header 02 00, then 2048 bytes with word n = n.
  -> 512 writes, last at addr 511 data 0x000001FF; words_loaded=512; cpu_run=1.
- Reset mid-load: rst_n=0 for one cycle after 6 bytes of the Basic load stream.
  -> all outputs 0, state IDLE; a further in_valid is not accepted until a new start.
- Reload from DONE: after Basic load, start then 00 01 12 34 56 78.
  -> cpu_run drops on the start edge; write addr 0 data 0x12345678; cpu_run=1 again; words_loaded=1.
